// File: rtl/sdram_cmd_monitor_if.sv
// SDRAM command bus as seen on the wires toward the device.
// The controller side drives it; the monitor only observes it.
interface sdram_cmd_monitor_if;
  logic        clke;
  logic [3:0]  cmd;
  logic [12:0] aram;
  logic [1:0]  ba;

  modport master (output clke, cmd, aram, ba);
  modport slave  (input  clke, cmd, aram, ba);
endinterface

// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command-bus checker: init sequence, mode register, open banks,
// command spacing, and a sticky first-violation error code.
module sdram_cmd_monitor #(
  parameter int TRP       = 3,
  parameter int TRFC      = 8,
  parameter int TMRD      = 2,
  parameter int REFRESHES = 2,
  parameter int MODES     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sdram_cmd_monitor_if.slave   bus,
  output logic                 init_done_o,
  output logic [12:0]          mode_reg_o,
  output logic [3:0]           bank_open_o,
  output logic [15:0]          ref_count_o,
  output logic                 error_o,
  output logic [3:0]           err_code_o
);

  typedef enum logic [2:0] {S_PWRUP, S_PRE, S_REF, S_MODE, S_READY} state_t;
  typedef enum logic [1:0] {K_PRE, K_REF, K_MODE} kind_t;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_BT    = 4'b0110;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  localparam logic [7:0] TRP_LOAD  = 8'(TRP - 1);
  localparam logic [7:0] TRFC_LOAD = 8'(TRFC - 1);
  localparam logic [7:0] TMRD_LOAD = 8'(TMRD - 1);
  localparam logic [7:0] REF_LAST  = 8'(REFRESHES - 1);
  localparam logic [7:0] MODE_LAST = 8'(MODES - 1);

  state_t      state_q;
  kind_t       kind_q;
  logic [7:0]  timer_q;
  logic [7:0]  refInit_q;
  logic [7:0]  modeInit_q;
  logic        initDone_q;
  logic [12:0] modeReg_q;
  logic [3:0]  bankOpen_q;
  logic [15:0] refCount_q;
  logic        error_q;
  logic [3:0]  errCode_q;
  logic [3:0]  errCode_d;

  logic isActiveCmd, isAct, isRdWr, isBt, isPre, isRef, isLmr;

  assign isActiveCmd = !bus.cmd[3] && (bus.cmd != CMD_NOP);
  assign isAct  = (bus.cmd == CMD_ACT);
  assign isRdWr = (bus.cmd == CMD_READ) || (bus.cmd == CMD_WRITE);
  assign isBt   = (bus.cmd == CMD_BT);
  assign isPre  = (bus.cmd == CMD_PRE);
  assign isRef  = (bus.cmd == CMD_REF);
  assign isLmr  = (bus.cmd == CMD_LMR);

  // Violation code for the command on the bus this cycle, highest priority first.
  always_comb begin
    errCode_d = 4'd0;
    if (isActiveCmd && (!bus.clke || state_q == S_PWRUP)) begin
      errCode_d = 4'd1;
    end else if (!bus.clke && state_q == S_READY) begin
      errCode_d = 4'd10;
    end else if (isActiveCmd && timer_q != 8'd0) begin
      case (kind_q)
        K_PRE:   errCode_d = 4'd3;
        K_REF:   errCode_d = 4'd4;
        default: errCode_d = 4'd5;
      endcase
    end else if (isPre && !bus.aram[10] && state_q == S_PRE) begin
      errCode_d = 4'd2;
    end else if (((isAct || isRdWr || isBt) && state_q != S_READY) ||
                 (isRef && state_q == S_PRE) ||
                 (isLmr && (state_q == S_PRE || state_q == S_REF))) begin
      errCode_d = 4'd6;
    end else if (isRdWr && state_q == S_READY && !bankOpen_q[bus.ba]) begin
      errCode_d = 4'd7;
    end else if (isAct && state_q == S_READY && bankOpen_q[bus.ba]) begin
      errCode_d = 4'd8;
    end else if (isRef && bankOpen_q != 4'd0) begin
      errCode_d = 4'd9;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_PWRUP;
      kind_q     <= K_PRE;
      timer_q    <= 8'd0;
      refInit_q  <= 8'd0;
      modeInit_q <= 8'd0;
      initDone_q <= 1'b0;
      modeReg_q  <= 13'd0;
      bankOpen_q <= 4'd0;
      refCount_q <= 16'd0;
      error_q    <= 1'b0;
      errCode_q  <= 4'd0;
    end else begin
      if (isPre) begin
        timer_q <= TRP_LOAD;
        kind_q  <= K_PRE;
      end else if (isRef) begin
        timer_q <= TRFC_LOAD;
        kind_q  <= K_REF;
      end else if (isLmr) begin
        timer_q <= TMRD_LOAD;
        kind_q  <= K_MODE;
      end else if (timer_q != 8'd0) begin
        timer_q <= timer_q - 8'd1;
      end

      if (isLmr) modeReg_q <= bus.aram;

      case (state_q)
        S_PWRUP: if (bus.clke) state_q <= S_PRE;
        S_PRE:   if (isPre && bus.aram[10]) state_q <= S_REF;
        S_REF: begin
          if (isRef) begin
            refInit_q <= refInit_q + 8'd1;
            if (refInit_q == REF_LAST) state_q <= S_MODE;
          end
        end
        S_MODE: begin
          if (isLmr) begin
            modeInit_q <= modeInit_q + 8'd1;
            if (modeInit_q == MODE_LAST) begin
              state_q    <= S_READY;
              initDone_q <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (isAct) bankOpen_q[bus.ba] <= 1'b1;
          if (isPre) begin
            if (bus.aram[10]) bankOpen_q <= 4'd0;
            else              bankOpen_q[bus.ba] <= 1'b0;
          end
          if (isRef && refCount_q != 16'hFFFF) refCount_q <= refCount_q + 16'd1;
        end
        default: state_q <= S_PWRUP;
      endcase

      // Only the first violation is kept; monitoring carries on regardless.
      if (!error_q && errCode_d != 4'd0) begin
        error_q   <= 1'b1;
        errCode_q <= errCode_d;
      end
    end
  end

  assign init_done_o = initDone_q;
  assign mode_reg_o  = modeReg_q;
  assign bank_open_o = bankOpen_q;
  assign ref_count_o = refCount_q;
  assign error_o     = error_q;
  assign err_code_o  = errCode_q;

endmodule
